// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Contents: default parameters, FSM state encoding and the {pc, instr} FIFO entry.
package fetch_unit_pkg;

    localparam int unsigned XLEN                  = 32;
    localparam logic [31:0] FETCH_RESET_PC        = 32'h0000_0000;
    localparam int unsigned FETCH_FIFO_DEPTH      = 4;
    localparam int unsigned FETCH_MAX_OUTSTANDING = 2;

    typedef enum logic {
        FETCH_ST_FETCH = 1'b0,
        FETCH_ST_FLUSH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle of the fetch stage: memory request/response, redirect and the
// instruction channel toward execute.
// master: fetch unit side (drives req_*, instr_*); slave: memory/execute side.
interface fetch_unit_if;

    logic                              req_valid;
    logic [fetch_unit_pkg::XLEN-1:0]   req_addr;
    logic                              req_ready;
    logic                              resp_valid;
    logic [fetch_unit_pkg::XLEN-1:0]   resp_data;
    logic                              redirect_valid;
    logic [fetch_unit_pkg::XLEN-1:0]   redirect_pc;
    logic                              instr_valid;
    logic                              instr_ready;
    logic [fetch_unit_pkg::XLEN-1:0]   instr;
    logic [fetch_unit_pkg::XLEN-1:0]   instr_pc;

    modport master (
        output req_valid, req_addr, instr_valid, instr, instr_pc,
        input  req_ready, resp_valid, resp_data, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  req_valid, req_addr, instr_valid, instr, instr_pc,
        output req_ready, resp_valid, resp_data, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of {pc, instr} entries.
// Ports: clk, reset (sync, active-low), push/push_data, pop, clear (drops all
// entries), head (entry at the read pointer), count, empty, full.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         clear,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;
    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word fetches under a credit limit,
// buffers in-order responses and hands {instr, instr_pc} to execute. A redirect
// flushes the buffer and drops every in-flight response before refetching.
// Ports: clk, reset (sync, active-low), bus (fetch_unit_if.master).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = FETCH_RESET_PC,
    parameter int unsigned FIFO_DEPTH      = FETCH_FIFO_DEPTH,
    parameter int unsigned MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_nxt;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] outstanding_nxt;
    logic [OW-1:0] drop_count;
    logic [OW-1:0] drop_count_nxt;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;
    logic          credit_ok;
    logic          req_valid_c;
    logic          instr_valid_c;
    logic          push;
    logic          pop;
    logic          clear;

    // Issue only if every in-flight word is guaranteed a FIFO slot.
    assign credit_ok = (32'(outstanding) < MAX_OUTSTANDING) &&
                       ((32'(outstanding) + 32'(fifo_count)) < FIFO_DEPTH);

    // In FETCH all in-flight requests belong to the current stream, so the
    // returning word is the oldest: fetch_pc minus four per outstanding request.
    assign push_entry.pc    = fetch_pc - (32'(outstanding) << 2);
    assign push_entry.instr = bus.resp_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= FETCH_ST_FETCH;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_count  <= '0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            outstanding <= outstanding_nxt;
            drop_count  <= drop_count_nxt;
        end
    end

    // Next state, counters and handshake enables.
    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        outstanding_nxt = outstanding;
        drop_count_nxt  = drop_count;
        req_valid_c     = 1'b0;
        instr_valid_c   = 1'b0;
        push            = 1'b0;
        pop             = 1'b0;
        clear           = 1'b0;

        // Any response retires one in-flight request regardless of state.
        if (bus.resp_valid && (outstanding != '0)) begin
            outstanding_nxt = outstanding - OW'(1);
        end

        if (bus.redirect_valid) begin
            clear          = 1'b1;
            fetch_pc_nxt   = bus.redirect_pc & ~32'h3;
            drop_count_nxt = outstanding_nxt;
            state_nxt      = (outstanding_nxt != '0) ? FETCH_ST_FLUSH : FETCH_ST_FETCH;
        end else begin
            case (state)
                FETCH_ST_FETCH: begin
                    req_valid_c   = reset && credit_ok;
                    instr_valid_c = reset && !fifo_empty;
                    push          = bus.resp_valid;
                    pop           = instr_valid_c && bus.instr_ready;
                    if (req_valid_c && bus.req_ready) begin
                        fetch_pc_nxt    = fetch_pc + 32'd4;
                        outstanding_nxt = outstanding_nxt + OW'(1);
                    end
                end
                FETCH_ST_FLUSH: begin
                    if (bus.resp_valid && (drop_count != '0)) begin
                        drop_count_nxt = drop_count - OW'(1);
                    end
                    if (drop_count_nxt == '0) begin
                        state_nxt = FETCH_ST_FETCH;
                    end
                end
                default: state_nxt = FETCH_ST_FETCH;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (clear),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.req_valid   = req_valid_c;
    assign bus.req_addr    = fetch_pc;
    assign bus.instr_valid = instr_valid_c;
    assign bus.instr       = fifo_head.instr;
    assign bus.instr_pc    = fifo_head.pc;

    // Protocol checks on the memory side and the credit invariant.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(bus.resp_valid && (outstanding == '0)))
                else $error("fetch_unit: resp_valid with no outstanding request");
            assert (!(push && fifo_full))
                else $error("fetch_unit: push into full instruction buffer");
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table (the table also
// plays the memory) plus a latency-3 streaming sequence with a small memory model.
module tb_fetch_unit;

    logic clk;
    logic reset;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC        (32'h0000_0000),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rrdy;
        logic        rv;
        logic [31:0] rdata;
        logic        dv;
        logic [31:0] dpc;
        logic        irdy;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        chk_head;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    vec_t  vq[$];
    mreq_t mq[$];
    int    n_vec;
    int    n_miss;

    localparam logic [31:0] KEY = 32'h1357_9BDF;

    function automatic vec_t mk(input logic rst, input logic rrdy, input logic rv,
                                input logic [31:0] rdata, input logic dv,
                                input logic [31:0] dpc, input logic irdy,
                                input logic e_rv, input logic [31:0] e_addr,
                                input logic e_iv, input logic [31:0] e_instr,
                                input logic [31:0] e_pc, input logic chk_head);
        vec_t v;
        v.rst = rst; v.rrdy = rrdy; v.rv = rv; v.rdata = rdata;
        v.dv = dv; v.dpc = dpc; v.irdy = irdy;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_instr = e_instr; v.e_pc = e_pc; v.chk_head = chk_head;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.resp_data      = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
    endtask

    initial begin
        int          t;
        int          got;
        int          max_inflight;
        logic        ok;
        logic [31:0] exp_pc;

        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b0;
        idle_inputs();

        // Reset state, then latency-1 streaming with execute always ready.
        vq.push_back(mk(0,0,0,32'h0,        0,32'h0,1, 0,32'h0000_0000,0,32'h0,        32'h0,1));
        vq.push_back(mk(1,1,0,32'h0,        0,32'h0,1, 1,32'h0000_0000,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,1,1,32'hA000_0000,0,32'h0,1, 1,32'h0000_0004,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,1,1,32'hA000_0004,0,32'h0,1, 1,32'h0000_0008,1,32'hA000_0000,32'h0,0));
        vq.push_back(mk(1,1,1,32'hA000_0008,0,32'h0,1, 1,32'h0000_000C,1,32'hA000_0004,32'h4,0));
        // Mid-stream reset: both valids drop, fetch restarts at the reset PC.
        vq.push_back(mk(0,1,0,32'h0,        0,32'h0,1, 0,32'h0000_0010,0,32'h0,        32'h0,0));
        vq.push_back(mk(0,0,0,32'h0,        0,32'h0,0, 0,32'h0000_0000,0,32'h0,        32'h0,1));
        // Execute stalled: exactly four requests fit, then drain and resume at 0x10.
        vq.push_back(mk(1,1,0,32'h0,        0,32'h0,0, 1,32'h0000_0000,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,1,1,32'hA000_0000,0,32'h0,0, 1,32'h0000_0004,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,1,1,32'hA000_0004,0,32'h0,0, 1,32'h0000_0008,1,32'hA000_0000,32'h0,0));
        vq.push_back(mk(1,1,1,32'hA000_0008,0,32'h0,0, 1,32'h0000_000C,1,32'hA000_0000,32'h0,0));
        vq.push_back(mk(1,1,1,32'hA000_000C,0,32'h0,0, 0,32'h0000_0010,1,32'hA000_0000,32'h0,0));
        vq.push_back(mk(1,1,0,32'h0,        0,32'h0,0, 0,32'h0000_0010,1,32'hA000_0000,32'h0,0));
        vq.push_back(mk(1,1,0,32'h0,        0,32'h0,1, 0,32'h0000_0010,1,32'hA000_0000,32'h0,0));
        vq.push_back(mk(1,1,0,32'h0,        0,32'h0,1, 1,32'h0000_0010,1,32'hA000_0004,32'h4,0));
        vq.push_back(mk(1,1,1,32'hA000_0010,0,32'h0,1, 1,32'h0000_0014,1,32'hA000_0008,32'h8,0));
        vq.push_back(mk(1,0,1,32'hA000_0014,0,32'h0,1, 1,32'h0000_0018,1,32'hA000_000C,32'hC,0));
        vq.push_back(mk(1,0,0,32'h0,        0,32'h0,1, 1,32'h0000_0018,1,32'hA000_0010,32'h10,0));
        vq.push_back(mk(1,0,0,32'h0,        0,32'h0,1, 1,32'h0000_0018,1,32'hA000_0014,32'h14,0));
        vq.push_back(mk(1,0,0,32'h0,        0,32'h0,1, 1,32'h0000_0018,0,32'h0,        32'h0,0));
        // Two in flight, redirect to 0x103: both responses dropped, refetch 0x100.
        vq.push_back(mk(1,1,0,32'h0,        0,32'h0,1, 1,32'h0000_0018,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,1,0,32'h0,        0,32'h0,1, 1,32'h0000_001C,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,1,0,32'h0,        1,32'h103,1,0,32'h0000_0020,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,1,1,32'hA000_0018,0,32'h0,1, 0,32'h0000_0100,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,1,0,32'h0,        0,32'h0,1, 0,32'h0000_0100,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,1,1,32'hA000_001C,0,32'h0,1, 0,32'h0000_0100,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,1,0,32'h0,        0,32'h0,1, 1,32'h0000_0100,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,0,1,32'hA000_0100,0,32'h0,0, 1,32'h0000_0104,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,1,0,32'h0,        0,32'h0,0, 1,32'h0000_0104,1,32'hA000_0100,32'h100,0));
        // Redirect with a response and a pending instr handshake in the same cycle.
        vq.push_back(mk(1,1,1,32'hA000_0104,1,32'h200,1,0,32'h0000_0108,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,1,0,32'h0,        0,32'h0,1, 1,32'h0000_0200,0,32'h0,        32'h0,0));
        // Redirect while flushing re-targets and keeps dropping.
        vq.push_back(mk(1,1,0,32'h0,        0,32'h0,1, 1,32'h0000_0204,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,1,0,32'h0,        1,32'h300,1,0,32'h0000_0208,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,1,1,32'hA000_0200,1,32'h404,1,0,32'h0000_0300,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,1,0,32'h0,        0,32'h0,1, 0,32'h0000_0404,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,1,1,32'hA000_0204,0,32'h0,1, 0,32'h0000_0404,0,32'h0,        32'h0,0));
        // Address wrap from 0xFFFF_FFFC to 0.
        vq.push_back(mk(1,1,0,32'h0,        1,32'hFFFF_FFFF,1,0,32'h0000_0404,0,32'h0,   32'h0,0));
        vq.push_back(mk(1,1,0,32'h0,        0,32'h0,1, 1,32'hFFFF_FFFC,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,0,1,32'hCAFE_F00D,0,32'h0,0, 1,32'h0000_0000,0,32'h0,        32'h0,0));
        vq.push_back(mk(1,0,0,32'h0,        0,32'h0,1, 1,32'h0000_0000,1,32'hCAFE_F00D,32'hFFFF_FFFC,0));

        repeat (2) @(posedge clk);

        foreach (vq[i]) begin
            @(negedge clk);
            reset              = vq[i].rst;
            bus.req_ready      = vq[i].rrdy;
            bus.resp_valid     = vq[i].rv;
            bus.resp_data      = vq[i].rdata;
            bus.redirect_valid = vq[i].dv;
            bus.redirect_pc    = vq[i].dpc;
            bus.instr_ready    = vq[i].irdy;
            #1;
            n_vec++;
            ok = (bus.req_valid === vq[i].e_rv) && (bus.req_addr === vq[i].e_addr) &&
                 (bus.instr_valid === vq[i].e_iv);
            if (vq[i].e_iv || vq[i].chk_head) begin
                ok = ok && (bus.instr === vq[i].e_instr) && (bus.instr_pc === vq[i].e_pc);
            end
            if (!ok) begin
                n_miss++;
                $display("FAIL vec%0d: got rv=%b addr=%h iv=%b instr=%h pc=%h, want rv=%b addr=%h iv=%b instr=%h pc=%h",
                         i, bus.req_valid, bus.req_addr, bus.instr_valid, bus.instr, bus.instr_pc,
                         vq[i].e_rv, vq[i].e_addr, vq[i].e_iv, vq[i].e_instr, vq[i].e_pc);
            end
        end

        // Latency-3 streaming: at most two requests in flight, eight words in order.
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        mq.delete();
        got          = 0;
        max_inflight = 0;
        t            = 0;
        while (got < 8 && t < 200) begin
            reset         = 1'b1;
            bus.req_ready = 1'b1;
            bus.instr_ready = ((t % 3) != 1);
            if (mq.size() > 0 && mq[0].due <= t) begin
                bus.resp_valid = 1'b1;
                bus.resp_data  = mq[0].addr ^ KEY;
                void'(mq.pop_front());
            end else begin
                bus.resp_valid = 1'b0;
                bus.resp_data  = '0;
            end
            #1;
            if (bus.req_valid && bus.req_ready) begin
                mq.push_back('{bus.req_addr, t + 3});
            end
            if (int'(mq.size()) > max_inflight) begin
                max_inflight = mq.size();
            end
            if (bus.instr_valid && bus.instr_ready) begin
                exp_pc = 32'(got) << 2;
                n_vec++;
                if (bus.instr_pc !== exp_pc || bus.instr !== (exp_pc ^ KEY)) begin
                    n_miss++;
                    $display("FAIL lat3_word%0d: got pc=%h instr=%h, want pc=%h instr=%h",
                             got, bus.instr_pc, bus.instr, exp_pc, exp_pc ^ KEY);
                end
                got++;
            end
            @(negedge clk);
            t++;
        end
        idle_inputs();

        n_vec++;
        if (got < 8) begin
            n_miss++;
            $display("FAIL lat3_timeout: got %0d words, want 8", got);
        end
        n_vec++;
        if (max_inflight != 2) begin
            n_miss++;
            $display("FAIL lat3_inflight: got max %0d in flight, want 2", max_inflight);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
